// File: rtl/sortn_seq.sv
// sortn_seq: iterative odd-even transposition sorter with start/busy/done handshake.
// Ports: clk, rst_n (async, active-low), start/desc (request + direction, sampled in IDLE),
//        din/dout (N elements of W bits, element i at [i*W +: W]), busy, done (1-cycle pulse).
// Optional: define SORTN_EARLY_EXIT_EN to finish after two consecutive exchange-free phases.
module sortn_seq #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           desc,
    input  logic [N*W-1:0] din,
    output logic [N*W-1:0] dout,
    output logic           busy,
    output logic           done
);
    localparam int PW = $clog2(N);
    typedef enum logic {IDLE, SORT} state_t;
    state_t               state;
    logic [N-1:0][W-1:0]  v, nxt;
    logic                 mode;
    logic [PW-1:0]        ph;
    logic                 fin;
    assign dout = v;
    // pairs in one phase never overlap, so each element is written at most once
    always_comb begin
        nxt = v;
        for (int i = 0; i < N - 1; i++)
            if (i[0] == ph[0] && (mode ? v[i] < v[i+1] : v[i] > v[i+1])) begin
                nxt[i]   = v[i+1];
                nxt[i+1] = v[i];
            end
    end
`ifdef SORTN_EARLY_EXIT_EN
    logic prev_sw;
    // a swap only happens on strictly unequal values, so any exchange changes the array
    logic any;
    assign any = nxt != v;
    assign fin = ph == PW'(N - 1) || (!any && !prev_sw);
`else
    assign fin = ph == PW'(N - 1);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            v     <= '0;
            mode  <= 1'b0;
            ph    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SORTN_EARLY_EXIT_EN
            prev_sw <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    v     <= din;
                    mode  <= desc;
                    ph    <= '0;
                    busy  <= 1'b1;
                    state <= SORT;
`ifdef SORTN_EARLY_EXIT_EN
                    // phase 0 has no predecessor, so it can never end the sort by itself
                    prev_sw <= 1'b1;
`endif
                end
            end else begin
                v  <= nxt;
                ph <= fin ? ph : ph + 1'b1;
`ifdef SORTN_EARLY_EXIT_EN
                prev_sw <= any;
`endif
                if (fin) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sortn_seq.sv
// tb_sortn_seq: directed and random checks of sortn_seq against a reference sorter model.
module tb_sortn_seq;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int NW = N * W;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          desc = 1'b0;
    logic [NW-1:0] din = '0;
    logic [NW-1:0] dout;
    logic          busy, done;
    int            checks = 0;
    int            failures = 0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [NW-1:0] m_dout = '0;
    logic [NW-1:0] m_res = '0;
    int            m_cnt = 0;
    int            m_lat = N;
`ifdef SORTN_EARLY_EXIT_EN
    localparam int SORTED_LAT = 2;
`else
    localparam int SORTED_LAT = 4;
`endif

    sortn_seq #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .desc(desc),
        .din(din), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] ref_sort(input logic [NW-1:0] d, input logic dsc);
        int a[N];
        int t;
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = int'(d[i*W +: W]);
        for (int i = 1; i < N; i++) begin
            t = a[i];
            for (int j = i; j > 0; j--) begin
                if (dsc ? a[j-1] < t : a[j-1] > t) begin
                    a[j] = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
        return r;
    endfunction

`ifdef SORTN_EARLY_EXIT_EN
    function automatic int ref_lat(input logic [NW-1:0] d, input logic dsc);
        int a[N];
        int t;
        bit prev = 1'b1;
        bit s;
        for (int i = 0; i < N; i++) a[i] = int'(d[i*W +: W]);
        for (int p = 0; p < N; p++) begin
            s = 1'b0;
            for (int i = p % 2; i + 1 < N; i += 2)
                if (dsc ? a[i] < a[i+1] : a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t; s = 1'b1;
                end
            if (p == N - 1 || (!s && !prev)) return p + 1;
            prev = s;
        end
        return N;
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dout = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    m_busy = 1'b0; m_done = 1'b1; m_dout = m_res;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_res  = ref_sort(din, desc);
`ifdef SORTN_EARLY_EXIT_EN
                m_lat = ref_lat(din, desc);
`else
                m_lat = N;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        if (!m_busy) check("dout", 64'(dout), 64'(m_dout));
    end

    task automatic launch(input logic [NW-1:0] d, input logic dsc);
        din = d; desc = dsc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_e0", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input logic [NW-1:0] exp, input int lat, input string nm, input int k0);
        int k = k0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_lat"}, 64'(k), 64'(lat));
        check({nm, "_dout"}, 64'(dout), 64'(exp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        launch(16'h0213, 1'b0); wait_done(16'h3210, 4, "asc", 0);
        launch(16'h0213, 1'b1); wait_done(16'h0123, 4, "desc", 0);
        launch(16'h3210, 1'b0); wait_done(16'h3210, SORTED_LAT, "sorted", 0);
        launch(16'h00FF, 1'b0); wait_done(16'hFF00, 4, "extremes", 0);
        launch(16'h0213, 1'b0);
        @(negedge clk);
        din = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(16'h3210, 4, "ignore_start", 2);
        launch(16'h1302, 1'b0); wait_done(16'h3210, 4, "start_on_done", 0);
        launch(16'h0213, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'd0);
        check("async_dout", 64'(dout), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        launch(16'h1032, 1'b0); wait_done(16'h3210, 4, "after_rst", 0);
        repeat (400) begin
            @(negedge clk);
            start = $urandom_range(0, 3) == 0;
            desc = 1'($urandom);
            for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
